// File: rtl/local_ctrl_layer_param_pkg.sv
// Shared types and width helpers for the layer-local sequencer.
package local_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_SAVE,
      S_RE,
      S_DONE
   } state_t;

   // Address width for a memory of 'depth' entries, never narrower than 1 bit.
   function automatic int addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Width of the pass index output.
   function automatic int pass_w(input int n_pass);
      return $clog2(n_pass) + 1;
   endfunction

endpackage

// File: rtl/local_ctrl_layer_param_if.sv
// Control/status bundle of the layer-local sequencer.
// Optional macro LCTRL_ABORT_EN adds the abort_i input.
interface local_ctrl_layer_param_if #(
   parameter int CNT_W  = 13,
   parameter int X_AW   = 6,
   parameter int W_AW   = 7,
   parameter int T_AW   = 5,
   parameter int PASS_W = 2
);
`ifdef LCTRL_ABORT_EN
   logic              abort_i;
`endif
   logic              start_i;
   logic              temp_start_i;
   logic [CNT_W-1:0]  cnt_i;
   logic [W_AW-1:0]   w_addr_o;
   logic              w_en_o;
   logic [X_AW-1:0]   x_addr_o;
   logic              x_en_o;
   logic              mac_en_o;
   logic              mac_clear_o;
   logic              relu_en_o;
   logic [PASS_W-1:0] pass_o;
   logic [T_AW-1:0]   temp_wr_addr_o;
   logic              temp_wr_en_o;
   logic              temp_clear_o;
   logic              busy_o;
   logic              done_o;
   logic              all_done_o;

   modport slave (
`ifdef LCTRL_ABORT_EN
      input  abort_i,
`endif
      input  start_i, temp_start_i, cnt_i,
      output w_addr_o, w_en_o, x_addr_o, x_en_o, mac_en_o, mac_clear_o, relu_en_o,
      output pass_o, temp_wr_addr_o, temp_wr_en_o, temp_clear_o, busy_o, done_o, all_done_o
   );

   modport master (
`ifdef LCTRL_ABORT_EN
      output abort_i,
`endif
      output start_i, temp_start_i, cnt_i,
      input  w_addr_o, w_en_o, x_addr_o, x_en_o, mac_en_o, mac_clear_o, relu_en_o,
      input  pass_o, temp_wr_addr_o, temp_wr_en_o, temp_clear_o, busy_o, done_o, all_done_o
   );

endinterface

// File: rtl/local_ctrl_layer_param_temp_writer.sv
// Temp-buffer write burst generator: TEMP_DEPTH/N_PASS consecutive writes per
// trigger, address held between bursts, clear pulse after the top entry.
module lctrl_temp_writer
   import local_ctrl_pkg::*;
#(
   parameter int TEMP_DEPTH = 32,
   parameter int N_PASS     = 2,
   parameter int T_AW       = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush,
   input  logic            start,
   output logic [T_AW-1:0] wr_addr,
   output logic            wr_en,
   output logic            clear
);
   localparam int BURST = TEMP_DEPTH / N_PASS;
   localparam int REM_W = addr_w(BURST);

   logic [REM_W-1:0] remain;

   // Burst down-counter, wrapping write address and post-wrap clear pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_addr <= '0;
         wr_en   <= 1'b0;
         remain  <= '0;
         clear   <= 1'b0;
      end else if (flush) begin
         wr_addr <= '0;
         wr_en   <= 1'b0;
         remain  <= '0;
         clear   <= 1'b0;
      end else begin
         clear <= 1'b0;
         if (wr_en) begin
            if (wr_addr == T_AW'(TEMP_DEPTH - 1)) begin
               wr_addr <= '0;
               clear   <= 1'b1;
            end else begin
               wr_addr <= wr_addr + T_AW'(1);
            end
            if (remain == '0) wr_en <= 1'b0;
            else remain <= remain - REM_W'(1);
         end else if (start) begin
            wr_en  <= 1'b1;
            remain <= REM_W'(BURST - 1);
         end
      end
   end
endmodule

// File: rtl/local_ctrl_layer_param.sv
// Layer-local sequencer: per start, N_PASS passes of IN_LEN buffer reads into
// the MAC, each followed by SAVE_CYC cycles for ReLU/writeback.
// Optional macro LCTRL_ABORT_EN adds abort_i (forces IDLE, flushes counters).
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing one tap read per cycle
// SAVE  | ReLU/writeback gap after a pass
// RE    | run complete, done_o high, final-count check
// DONE  | last image processed, held until reset
module local_ctrl_layer_param
   import local_ctrl_pkg::*;
#(
   parameter int IN_LEN     = 64,
   parameter int N_PASS     = 2,
   parameter int SAVE_CYC   = 4,
   parameter int RELU_DLY   = 2,
   parameter int TEMP_DEPTH = 32,
   parameter int CNT_W      = 13,
   parameter int FINAL_CNT  = 7879,
   parameter int X_AW       = addr_w(IN_LEN),
   parameter int W_AW       = addr_w(IN_LEN * N_PASS),
   parameter int T_AW       = addr_w(TEMP_DEPTH)
) (
   input logic clk_i,
   input logic rst_i,
   local_ctrl_layer_param_if.slave bus
);
   localparam int PASS_W = pass_w(N_PASS);
   localparam int SAVE_W = addr_w(SAVE_CYC);

   state_t            state;
   logic [X_AW-1:0]   tap;
   logic [W_AW-1:0]   w_addr;
   logic [PASS_W-1:0] pass;
   logic [SAVE_W-1:0] save_cnt;
   logic              w_en, mac_en, mac_clear, relu_pulse, relu_en;
   logic              done, all_done, busy;
   logic              abort;

`ifdef LCTRL_ABORT_EN
   assign abort = bus.abort_i;
`else
   assign abort = 1'b0;
`endif

   // Sequencer FSM with all its outputs registered alongside the state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         tap        <= '0;
         w_addr     <= '0;
         pass       <= '0;
         save_cnt   <= '0;
         w_en       <= 1'b0;
         mac_en     <= 1'b0;
         mac_clear  <= 1'b0;
         relu_pulse <= 1'b0;
         done       <= 1'b0;
         all_done   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         done       <= 1'b0;
         relu_pulse <= 1'b0;
         mac_en     <= w_en;
         mac_clear  <= w_en && (tap == '0);
         if (abort) begin
            state     <= S_IDLE;
            tap       <= '0;
            w_addr    <= '0;
            pass      <= '0;
            save_cnt  <= '0;
            w_en      <= 1'b0;
            mac_en    <= 1'b0;
            mac_clear <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (bus.start_i) begin
                  state  <= S_RUN;
                  busy   <= 1'b1;
                  w_en   <= 1'b1;
                  tap    <= '0;
                  w_addr <= '0;
                  pass   <= '0;
               end
               S_RUN: if (tap == X_AW'(IN_LEN - 1)) begin
                  state      <= S_SAVE;
                  w_en       <= 1'b0;
                  tap        <= '0;
                  w_addr     <= '0;
                  relu_pulse <= 1'b1;
                  save_cnt   <= SAVE_W'(SAVE_CYC - 1);
               end else begin
                  tap    <= tap + X_AW'(1);
                  w_addr <= w_addr + W_AW'(1);
               end
               S_SAVE: if (save_cnt == '0) begin
                  if (pass < PASS_W'(N_PASS - 1)) begin
                     state  <= S_RUN;
                     pass   <= pass + PASS_W'(1);
                     w_en   <= 1'b1;
                     w_addr <= W_AW'((int'(pass) + 1) * IN_LEN);
                  end else begin
                     state <= S_RE;
                     done  <= 1'b1;
                  end
               end else begin
                  save_cnt <= save_cnt - SAVE_W'(1);
               end
               S_RE: begin
                  busy <= 1'b0;
                  if (bus.cnt_i == CNT_W'(FINAL_CNT)) begin
                     state    <= S_DONE;
                     all_done <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_DONE: state <= S_DONE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // ReLU strobe: the first-SAVE-cycle pulse, delayed independently of the FSM.
   generate
      if (RELU_DLY == 0) begin : g_relu_direct
         assign relu_en = relu_pulse;
      end else begin : g_relu_dly
         logic [RELU_DLY-1:0] dly;
         // Shift the pulse through RELU_DLY stages; abort empties the line.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)      dly <= '0;
            else if (abort) dly <= '0;
            else            dly <= (dly << 1) | RELU_DLY'(relu_pulse);
         end
         assign relu_en = dly[RELU_DLY-1];
      end
   endgenerate

   lctrl_temp_writer #(
      .TEMP_DEPTH (TEMP_DEPTH),
      .N_PASS     (N_PASS),
      .T_AW       (T_AW)
   ) u_temp (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush   (abort),
      .start   (bus.temp_start_i),
      .wr_addr (bus.temp_wr_addr_o),
      .wr_en   (bus.temp_wr_en_o),
      .clear   (bus.temp_clear_o)
   );

   assign bus.w_addr_o    = w_addr;
   assign bus.w_en_o      = w_en;
   assign bus.x_addr_o    = tap;
   assign bus.x_en_o      = w_en;
   assign bus.mac_en_o    = mac_en;
   assign bus.mac_clear_o = mac_clear;
   assign bus.relu_en_o   = relu_en;
   assign bus.pass_o      = pass;
   assign bus.busy_o      = busy;
   assign bus.done_o      = done;
   assign bus.all_done_o  = all_done;
endmodule

// File: tb/tb_local_ctrl_layer_param.sv
// Bench for local_ctrl_layer_param: randomized runs and temp bursts compared
// against a cycle-timeline model derived from run/pass/burst arithmetic.
// Build with LCTRL_ABORT_EN to include the abort scenario.
module tb_local_ctrl_layer_param;
   localparam int IN_LEN = 64, N_PASS = 2, SAVE_CYC = 4, RELU_DLY = 2;
   localparam int TEMP_DEPTH = 32, CNT_W = 13, FINAL_CNT = 7879;
   localparam int X_AW = 6, W_AW = 7, T_AW = 5, PASS_W = 2;
   localparam int P = IN_LEN + SAVE_CYC;
   localparam int RUNLEN = N_PASS * P;
   localparam int BURST = TEMP_DEPTH / N_PASS;
   localparam int BIG = 1 << 30;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;
   logic exp_all_done = 1'b0;
   int   t_hold = 0;

   always #5 clk = ~clk;

   local_ctrl_layer_param_if #(.CNT_W(CNT_W), .X_AW(X_AW), .W_AW(W_AW),
                               .T_AW(T_AW), .PASS_W(PASS_W)) bus ();

   local_ctrl_layer_param #(
      .IN_LEN(IN_LEN), .N_PASS(N_PASS), .SAVE_CYC(SAVE_CYC), .RELU_DLY(RELU_DLY),
      .TEMP_DEPTH(TEMP_DEPTH), .CNT_W(CNT_W), .FINAL_CNT(FINAL_CNT),
      .X_AW(X_AW), .W_AW(W_AW), .T_AW(T_AW)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.w_en_o, bus.x_en_o, bus.mac_en_o, bus.mac_clear_o, bus.relu_en_o,
           bus.busy_o, bus.done_o, bus.all_done_o, bus.temp_wr_en_o, bus.temp_clear_o} !== 10'b0)
         $display("FAIL reset_flags got %b exp 0", {bus.w_en_o, bus.x_en_o, bus.mac_en_o,
                  bus.mac_clear_o, bus.relu_en_o, bus.busy_o, bus.done_o, bus.all_done_o,
                  bus.temp_wr_en_o, bus.temp_clear_o});
      else n_pass++;
      n_checks++;
      if ({bus.w_addr_o, bus.x_addr_o, bus.pass_o, bus.temp_wr_addr_o} !== '0)
         $display("FAIL reset_addr w=%0d x=%0d pass=%0d t=%0d exp all 0",
                  bus.w_addr_o, bus.x_addr_o, bus.pass_o, bus.temp_wr_addr_o);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.w_en_o, bus.busy_o, bus.done_o, bus.temp_wr_en_o} !== 4'b0)
         $display("FAIL idle_after_reset got %b exp 0",
                  {bus.w_en_o, bus.busy_o, bus.done_o, bus.temp_wr_en_o});
      else n_pass++;
      exp_all_done = 1'b0;
      t_hold = 0;
   endtask

   // Runs 'len' cycles with start_i high for cycles s_from..s_to and checks
   // every FSM-side output against the run timeline each cycle.
   task automatic run_scenario(input string name, input int len, input int s_from,
                               input int s_to, input logic [CNT_W-1:0] cnt_val);
      int starts[$];
      int idle_from, ad_from;
      int o, p, k, e_pass, e_x, e_w;
      logic e_wen, e_mac, e_clr, e_relu, e_done, e_busy, e_ad;
      idle_from = exp_all_done ? BIG : 0;
      ad_from = exp_all_done ? 0 : BIG;
      for (int c = 0; c < len; c++) begin
         if (c >= idle_from && c >= s_from && c <= s_to) begin
            starts.push_back(c);
            if (int'(cnt_val) == FINAL_CNT) begin
               ad_from = c + 2 + RUNLEN;
               idle_from = BIG;
            end else begin
               idle_from = c + 2 + RUNLEN;
            end
         end
      end
      bus.cnt_i = cnt_val;
      for (int c = 0; c < len; c++) begin
         e_wen = 0; e_mac = 0; e_clr = 0; e_relu = 0; e_done = 0; e_busy = 0;
         e_x = 0; e_w = 0; e_pass = -1;
         foreach (starts[r]) begin
            o = c - starts[r] - 1;
            if (o >= 0 && o < RUNLEN) begin
               p = o / P; k = o % P;
               e_busy = 1; e_pass = p;
               if (k < IN_LEN) begin e_wen = 1; e_x = k; e_w = p * IN_LEN + k; end
            end
            if (o == RUNLEN) begin e_done = 1; e_busy = 1; end
            if (o >= 1 && o - 1 < RUNLEN && (o - 1) % P < IN_LEN) begin
               e_mac = 1;
               if ((o - 1) % P == 0) e_clr = 1;
            end
            for (int q = 0; q < N_PASS; q++)
               if (o == q * P + IN_LEN + RELU_DLY) e_relu = 1;
         end
         e_ad = exp_all_done || (c >= ad_from);
         @(negedge clk);
         n_checks++;
         if (bus.w_en_o !== e_wen || bus.x_en_o !== e_wen)
            $display("FAIL %s c=%0d w_en/x_en got %b%b exp %b", name, c, bus.w_en_o, bus.x_en_o, e_wen);
         else n_pass++;
         n_checks++;
         if (bus.x_addr_o !== X_AW'(e_x))
            $display("FAIL %s c=%0d x_addr got %0d exp %0d", name, c, bus.x_addr_o, e_x);
         else n_pass++;
         n_checks++;
         if (bus.w_addr_o !== W_AW'(e_w))
            $display("FAIL %s c=%0d w_addr got %0d exp %0d", name, c, bus.w_addr_o, e_w);
         else n_pass++;
         n_checks++;
         if (bus.mac_en_o !== e_mac || bus.mac_clear_o !== e_clr)
            $display("FAIL %s c=%0d mac_en/clear got %b%b exp %b%b", name, c,
                     bus.mac_en_o, bus.mac_clear_o, e_mac, e_clr);
         else n_pass++;
         n_checks++;
         if (bus.relu_en_o !== e_relu)
            $display("FAIL %s c=%0d relu_en got %b exp %b", name, c, bus.relu_en_o, e_relu);
         else n_pass++;
         n_checks++;
         if (bus.done_o !== e_done || bus.busy_o !== e_busy || bus.all_done_o !== e_ad)
            $display("FAIL %s c=%0d done/busy/all_done got %b%b%b exp %b%b%b", name, c,
                     bus.done_o, bus.busy_o, bus.all_done_o, e_done, e_busy, e_ad);
         else n_pass++;
         if (e_pass >= 0) begin
            n_checks++;
            if (bus.pass_o !== PASS_W'(e_pass))
               $display("FAIL %s c=%0d pass got %0d exp %0d", name, c, bus.pass_o, e_pass);
            else n_pass++;
         end
         bus.start_i = (c >= s_from && c <= s_to);
      end
      bus.start_i = 1'b0;
      if (ad_from < len) exp_all_done = 1'b1;
   endtask

   task automatic test_single_run();
      run_scenario("single", RUNLEN + 8, 0, 0, CNT_W'($urandom_range(0, FINAL_CNT - 1)));
      run_scenario("held_start", RUNLEN + 12, 2, 2 + $urandom_range(1, 20),
                   CNT_W'($urandom_range(0, FINAL_CNT - 1)));
   endtask

   task automatic test_back_to_back();
      run_scenario("back_to_back", 2 * (RUNLEN + 2) + 6, 0, RUNLEN + 2,
                   CNT_W'($urandom_range(0, FINAL_CNT - 1)));
   endtask

   task automatic test_temp_burst();
      logic we[256];
      logic cl[256];
      int   ad[256];
      logic st;
      int   wa;
      for (int i = 0; i < 256; i++) begin we[i] = 0; cl[i] = 0; ad[i] = 0; end
      for (int c = 0; c < 200; c++) begin
         if (!we[c]) ad[c] = t_hold;
         @(negedge clk);
         n_checks++;
         if (bus.temp_wr_en_o !== we[c])
            $display("FAIL temp c=%0d wr_en got %b exp %b", c, bus.temp_wr_en_o, we[c]);
         else n_pass++;
         n_checks++;
         if (bus.temp_wr_addr_o !== T_AW'(ad[c]))
            $display("FAIL temp c=%0d wr_addr got %0d exp %0d", c, bus.temp_wr_addr_o, ad[c]);
         else n_pass++;
         n_checks++;
         if (bus.temp_clear_o !== cl[c])
            $display("FAIL temp c=%0d clear got %b exp %b", c, bus.temp_clear_o, cl[c]);
         else n_pass++;
         if (c == 0 || c == 5 || c == 20) st = 1'b1;
         else if (c > 40 && c < 150) st = ($urandom_range(0, 3) == 0);
         else st = 1'b0;
         bus.temp_start_i = st;
         if (st && !we[c]) begin
            for (int i = 1; i <= BURST; i++) begin
               wa = (t_hold + i - 1) % TEMP_DEPTH;
               we[c + i] = 1'b1;
               ad[c + i] = wa;
               if (wa == TEMP_DEPTH - 1) cl[c + i + 1] = 1'b1;
            end
            t_hold = (t_hold + BURST) % TEMP_DEPTH;
         end
      end
      bus.temp_start_i = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      bus.cnt_i = '0;
      for (int c = 0; c <= 21; c++) begin
         @(negedge clk);
         bus.start_i = (c == 0);
      end
      n_checks++;
      if (bus.x_addr_o !== X_AW'(20) || bus.w_en_o !== 1'b1)
         $display("FAIL pre_reset x_addr got %0d w_en %b exp 20 1", bus.x_addr_o, bus.w_en_o);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.w_en_o, bus.x_en_o, bus.mac_en_o, bus.busy_o, bus.done_o, bus.relu_en_o} !== 6'b0)
         $display("FAIL async_reset_flags got %b exp 0", {bus.w_en_o, bus.x_en_o,
                  bus.mac_en_o, bus.busy_o, bus.done_o, bus.relu_en_o});
      else n_pass++;
      n_checks++;
      if ({bus.x_addr_o, bus.w_addr_o, bus.pass_o, bus.temp_wr_addr_o} !== '0)
         $display("FAIL async_reset_addr x=%0d w=%0d pass=%0d t=%0d exp 0",
                  bus.x_addr_o, bus.w_addr_o, bus.pass_o, bus.temp_wr_addr_o);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      exp_all_done = 1'b0;
      t_hold = 0;
      run_scenario("restart", RUNLEN + 8, 1, 1, CNT_W'($urandom_range(0, FINAL_CNT - 1)));
   endtask

   task automatic test_final_cnt();
      run_scenario("final", RUNLEN + 10, 0, 0, CNT_W'(FINAL_CNT));
      run_scenario("after_done", RUNLEN + 10, 3, 3, CNT_W'($urandom_range(0, FINAL_CNT)));
   endtask

`ifdef LCTRL_ABORT_EN
   task automatic test_abort();
      bus.cnt_i = CNT_W'(FINAL_CNT);
      for (int c = 0; c < IN_LEN + 16; c++) begin
         @(negedge clk);
         if (c == IN_LEN + 1) begin
            n_checks++;
            if (bus.busy_o !== 1'b1 || bus.w_en_o !== 1'b0)
               $display("FAIL abort_pre busy/w_en got %b%b exp 10", bus.busy_o, bus.w_en_o);
            else n_pass++;
         end
         if (c == IN_LEN + 2) begin
            n_checks++;
            if (bus.busy_o !== 1'b0 || bus.pass_o !== '0 || bus.temp_wr_addr_o !== '0)
               $display("FAIL abort_idle busy=%b pass=%0d taddr=%0d exp 0 0 0",
                        bus.busy_o, bus.pass_o, bus.temp_wr_addr_o);
            else n_pass++;
         end
         if (c > IN_LEN + 1) begin
            n_checks++;
            if (bus.done_o !== 1'b0 || bus.relu_en_o !== 1'b0 || bus.w_en_o !== 1'b0)
               $display("FAIL abort_quiet c=%0d done/relu/w_en got %b%b%b exp 000",
                        c, bus.done_o, bus.relu_en_o, bus.w_en_o);
            else n_pass++;
         end
         bus.start_i = (c == 0);
         bus.temp_start_i = (c == 0);
         bus.abort_i = (c == IN_LEN + 1);
      end
      bus.temp_start_i = 1'b0;
      t_hold = 0;
      run_scenario("after_abort", RUNLEN + 8, 0, 0, CNT_W'($urandom_range(0, FINAL_CNT - 1)));
   endtask
`endif

   initial begin
      bus.start_i = 1'b0;
      bus.temp_start_i = 1'b0;
      bus.cnt_i = '0;
`ifdef LCTRL_ABORT_EN
      bus.abort_i = 1'b0;
`endif
      test_reset();
      test_single_run();
      test_back_to_back();
      test_temp_burst();
      test_reset_mid_run();
      test_final_cnt();
      test_reset();
`ifdef LCTRL_ABORT_EN
      test_abort();
`endif
      run_scenario("final_random", RUNLEN + 8, $urandom_range(0, 4), 5,
                   CNT_W'($urandom_range(0, FINAL_CNT - 1)));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
